// File: rtl/rr_channel_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rr_channel_mux_pkg
// Brief   : Mode encodings and select-width derivation for rr_channel_mux.
// Revision: 1.0
// ============================================================================
package rr_channel_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_channel_mux_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotate-priority finder; first request at or after ptr.
// Revision: 1.0
// ============================================================================
module rr_pick #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                gnt_vld
);

    localparam logic [SEL_W:0] c_chan_cnt = (SEL_W+1)'(CHANNELS);

    logic [SEL_W-1:0] w_rot_idx [CHANNELS];

    // Channel index visited at scan step k, wrapped modulo CHANNELS.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_rot
        logic [SEL_W:0] w_sum;
        assign w_sum        = {1'b0, ptr} + (SEL_W+1)'(k);
        assign w_rot_idx[k] = (w_sum >= c_chan_cnt) ? SEL_W'(w_sum - c_chan_cnt)
                                                    : w_sum[SEL_W-1:0];
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req[w_rot_idx[k]]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_rot_idx[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_channel_mux.sv
`default_nettype none
// ============================================================================
// Module  : rr_channel_mux
// Brief   : N:1 channel mux, fixed-select or round-robin, registered output.
// Revision: 1.0
// ============================================================================
module rr_channel_mux
    import rr_channel_mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SEL_W:0]   c_chan_cnt = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] c_last_ch  = SEL_W'(CHANNELS - 1);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_load_en;
    logic [SEL_W-1:0]    w_pick_idx;
    logic                w_pick_vld;
    logic [SEL_W-1:0]    w_gnt;
    logic                w_gnt_vld;
    logic [CHANNELS-1:0] w_onehot;
    logic [WIDTH-1:0]    w_data;
    logic                w_xfer;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_pick (
        .req     (in_valid),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick_idx),
        .gnt_vld (w_pick_vld)
    );

    assign w_load_en = !r_out_valid || out_ready;

    always_comb begin
        if (mode == MODE_RR) begin
            w_gnt     = w_pick_idx;
            w_gnt_vld = w_pick_vld;
        end else begin
            w_gnt     = sel;
            w_gnt_vld = ({1'b0, sel} < c_chan_cnt);
        end
    end

    // Decoded grant drives both the ready vector and the data mux; an
    // out-of-range fixed select simply matches no channel.
    always_comb begin
        w_onehot = '0;
        w_data   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_onehot[i] = w_gnt_vld;
                w_data      = in_data[i*WIDTH +: WIDTH];
            end
        end
        in_ready = (!rst && w_load_en) ? w_onehot : '0;
        w_xfer   = |(in_valid & in_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_chan  <= w_gnt;
                if (mode == MODE_RR) begin
                    r_rr_ptr <= (w_gnt == c_last_ch) ? '0 : w_gnt + 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_rr_channel_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_channel_mux
// Brief   : Directed bench for rr_channel_mux (8 and 5 channels) with a reference model.
// Revision: 1.0
// ============================================================================
module tb_rr_channel_mux;

    localparam int N  = 8;
    localparam int N5 = 5;
    localparam int W  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [2:0]     sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_chan;
    logic           out_valid;
    logic           out_ready;

    logic            mode5;
    logic [2:0]      sel5;
    logic [N5*W-1:0] in_data5;
    logic [N5-1:0]   in_valid5;
    logic [N5-1:0]   in_ready5;
    logic [W-1:0]    out_data5;
    logic [2:0]      out_chan5;
    logic            out_valid5;
    logic            out_ready5;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rr_channel_mux #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_channel_mux #(.WIDTH(W), .CHANNELS(N5)) dut5 (
        .clk(clk), .rst(rst), .mode(mode5), .sel(sel5),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
        .out_ready(out_ready5)
    );

    // Reference model of the 8-channel instance, stated in terms of the
    // arbitration rules: modulo scan from the pointer, one-word output stage.
    logic        m_valid;
    logic [W-1:0] m_data;
    int          m_chan;
    int          m_ptr;
    logic        e_gv;
    int          e_g;
    logic        e_load;
    logic [N-1:0] e_ready;

    always @* begin
        e_gv    = 1'b0;
        e_g     = 0;
        e_ready = '0;
        e_load  = !m_valid || out_ready;
        if (mode == 1'b0) begin
            e_g  = int'(sel);
            e_gv = (e_g < N);
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!e_gv && in_valid[(m_ptr + k) % N]) begin
                    e_gv = 1'b1;
                    e_g  = (m_ptr + k) % N;
                end
            end
        end
        if (!rst && e_load && e_gv) e_ready = N'(1) << e_g;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= 0;
            m_ptr   <= 0;
        end else if (e_load) begin
            if (e_gv && in_valid[e_g]) begin
                m_valid <= 1'b1;
                m_data  <= in_data[e_g*W +: W];
                m_chan  <= e_g;
                if (mode) m_ptr <= (e_g + 1) % N;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model out_valid", 32'(out_valid), 32'(m_valid));
            cmp("model out_data",  32'(out_data),  32'(m_data));
            cmp("model out_chan",  32'(out_chan),  32'(m_chan));
            cmp("model in_ready",  32'(in_ready),  32'(e_ready));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       md;
        logic [2:0] sl;
        logic [7:0] vl;
        logic       rd;
    } vec_t;

    vec_t mix [8] = '{
        '{1'b1, 3'd0, 8'h81, 1'b1}, '{1'b1, 3'd0, 8'h81, 1'b0},
        '{1'b1, 3'd0, 8'h18, 1'b1}, '{1'b1, 3'd0, 8'h00, 1'b1},
        '{1'b1, 3'd0, 8'hff, 1'b0}, '{1'b1, 3'd0, 8'hff, 1'b1},
        '{1'b0, 3'd5, 8'h20, 1'b1}, '{1'b1, 3'd0, 8'h24, 1'b1}
    };

    initial begin
        int rr_exp [6] = '{7, 0, 1, 2, 3, 4};
        int sk_exp [4] = '{2, 6, 2, 6};

        rst = 1'b1; mode = 1'b0; sel = 3'd0; in_valid = '0; out_ready = 1'b1;
        for (int i = 0; i < N; i++)  in_data[i*W +: W]  = W'(i + 1);
        for (int i = 0; i < N5; i++) in_data5[i*W +: W] = W'(i + 1);
        mode5 = 1'b0; sel5 = 3'd6; in_valid5 = '1; out_ready5 = 1'b1;

        step();
        chk_en = 1'b1;
        step();
        cmp("reset out_valid", 32'(out_valid), 32'd0);
        cmp("reset out_data",  32'(out_data),  32'd0);
        cmp("reset out_chan",  32'(out_chan),  32'd0);
        cmp("reset in_ready",  32'(in_ready),  32'd0);

        rst = 1'b0; in_valid = '1;
        for (int s = 0; s < N; s++) begin
            sel = 3'(s);
            step();
            cmp("fixed out_data", 32'(out_data), 32'(s + 1));
            cmp("fixed out_chan", 32'(out_chan), 32'(s));
        end

        mode = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            cmp("rr fair out_chan", 32'(out_chan), 32'(k % N));
            cmp("rr fair out_data", 32'(out_data), 32'(k % N + 1));
            cmp("rr fair out_valid", 32'(out_valid), 32'd1);
        end

        in_valid = 8'b0100_0100;
        for (int k = 0; k < 4; k++) begin
            step();
            cmp("rr skip out_chan", 32'(out_chan), 32'(sk_exp[k]));
        end

        mode = 1'b0; sel = 3'd0; in_valid = '1;
        step();
        cmp("bp first word", 32'(out_data), 32'h0001);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            cmp("bp hold data",     32'(out_data),  32'h0001);
            cmp("bp hold valid",    32'(out_valid), 32'd1);
            cmp("bp in_ready zero", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1; sel = 3'd1;
        step();
        cmp("bp resume 1", 32'(out_data), 32'h0002);
        sel = 3'd2;
        step();
        cmp("bp resume 2", 32'(out_data), 32'h0003);

        mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            cmp("pre-reset out_chan", 32'(out_chan), 32'(rr_exp[k]));
        end
        rst = 1'b1;
        step();
        cmp("midrst out_valid", 32'(out_valid), 32'd0);
        cmp("midrst out_data",  32'(out_data),  32'd0);
        cmp("midrst out_chan",  32'(out_chan),  32'd0);
        cmp("midrst in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        step();
        cmp("post-rst grant", 32'(out_chan), 32'd0);
        cmp("post-rst data",  32'(out_data), 32'h0001);

        mode = 1'b0; sel = 3'd3; in_valid = 8'hF7;
        #1;
        cmp("inv ch in_ready", 32'(in_ready), 32'h08);
        step();
        cmp("inv ch out_valid", 32'(out_valid), 32'd0);
        cmp("inv ch hold data", 32'(out_data),  32'h0001);
        cmp("inv ch in_ready2", 32'(in_ready),  32'h08);

        cmp("c5 sel6 in_ready",  32'(in_ready5),  32'd0);
        cmp("c5 sel6 out_valid", 32'(out_valid5), 32'd0);
        sel5 = 3'd4;
        #1;
        cmp("c5 sel4 in_ready", 32'(in_ready5), 32'h10);
        step();
        cmp("c5 sel4 out_data", 32'(out_data5), 32'h0005);
        cmp("c5 sel4 out_chan", 32'(out_chan5), 32'd4);

        for (int k = 0; k < 8; k++) begin
            mode = mix[k].md; sel = mix[k].sl; in_valid = mix[k].vl; out_ready = mix[k].rd;
            step();
        end
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
